// File: rtl/sfp_norm_ctrl_pkg.sv
// Shared types and default sizing for the sfp_row normalisation sequencer.
// Pure declarations: no timing or flow-control behaviour of its own.
package sfp_norm_ctrl_pkg;

   localparam int ROWS_MAX_DEF = 16;
   localparam int ADDR_W       = 4;
   localparam int SYNC_TO_DEF  = 255;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ACC,
      ST_SYNC,
      ST_DIV,
      ST_FIN
   } state_t;

   function automatic logic [ADDR_W:0] clamp_rows(input logic [ADDR_W:0] req,
                                                  input logic [ADDR_W:0] lim);
      return (req > lim) ? lim : req;
   endfunction

endpackage

// File: rtl/sfp_norm_ctrl_if.sv
// Control, pmem/result strobe and peer-sync signals of one sfp_row sequencer.
// master = sequencer side, slave = host/datapath side.
interface sfp_norm_ctrl_if
   import sfp_norm_ctrl_pkg::*;
;
   logic              start;
   logic [ADDR_W:0]   num_rows;
   logic              peer_rdy;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic              acc;
   logic              div;
   logic              fifo_ext_rd;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic              sync_rdy;
   logic              busy;
   logic              done;
   logic              err;

   modport master (
      input  start, num_rows, peer_rdy,
      output rd_en, rd_addr, acc, div, fifo_ext_rd, wr_en, wr_addr,
             sync_rdy, busy, done, err
   );

   modport slave (
      output start, num_rows, peer_rdy,
      input  rd_en, rd_addr, acc, div, fifo_ext_rd, wr_en, wr_addr,
             sync_rdy, busy, done, err
   );

endinterface

// File: rtl/sfp_norm_ctrl_issue_pipe.sv
// Delay line: read strobe -> acc|div/fifo_ext_rd at +1, wr_en/wr_addr at +2 (DIV only).
// No backpressure; every issued read is consumed on a fixed schedule.
module sfp_norm_ctrl_issue_pipe
   import sfp_norm_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic              phase_div,
   output logic              acc,
   output logic              div,
   output logic              fifo_ext_rd,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr
);

   logic              v1;
   logic              p1;
   logic [ADDR_W-1:0] a1;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         v1      <= 1'b0;
         p1      <= 1'b0;
         a1      <= '0;
         wr_en   <= 1'b0;
         wr_addr <= '0;
      end else begin
         v1      <= rd_en;
         p1      <= phase_div;
         a1      <= rd_addr;
         wr_en   <= v1 & p1;
         wr_addr <= (v1 & p1) ? a1 : '0;
      end
   end

   // the peer FIFO pop must stay locked to div, so both come from one term
   assign acc         = v1 & ~p1;
   assign div         = v1 & p1;
   assign fifo_ext_rd = v1 & p1;

endmodule

// File: rtl/sfp_norm_ctrl.sv
// Pass sequencer IDLE->ACC->SYNC->DIV->FIN; ACC n+1 cycles, DIV n+2, done one cycle after FIN.
// Stalls only in SYNC waiting for peer_rdy, bounded by SYNC_TO (then err + done).
module sfp_norm_ctrl
   import sfp_norm_ctrl_pkg::*;
#(
   parameter int ROWS_MAX = ROWS_MAX_DEF,
   parameter int SYNC_TO  = SYNC_TO_DEF
) (
   input  logic            clk,
   input  logic            reset_n,
   sfp_norm_ctrl_if.master bus
);

   localparam int               AW1      = ADDR_W + 1;
   localparam int               WAIT_W   = $clog2(SYNC_TO + 1);
   localparam logic [ADDR_W:0]  ROWS_LIM = AW1'(ROWS_MAX);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(SYNC_TO);

   state_t            state, state_nxt;
   logic [ADDR_W:0]   n_q, n_req, row_q;
   logic [WAIT_W-1:0] wait_q;
   logic              sync_rdy_q, done_q, err_q;
   logic              start_ok, sync_go, timeout;
   logic              rd_en, phase_div;
   logic [ADDR_W-1:0] rd_addr;

   assign n_req     = clamp_rows(bus.num_rows, ROWS_LIM);
   assign start_ok  = (state == ST_IDLE) && bus.start;
   assign sync_go   = (state == ST_SYNC) && sync_rdy_q && bus.peer_rdy;
   // a peer arriving in the last wait cycle still wins over the timeout
   assign timeout   = (state == ST_SYNC) && !sync_go && (wait_q == WAIT_MAX);
   assign rd_en     = ((state == ST_ACC) || (state == ST_DIV)) && (row_q < n_q);
   assign rd_addr   = rd_en ? row_q[ADDR_W-1:0] : '0;
   assign phase_div = (state == ST_DIV);

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (start_ok) state_nxt = (n_req == '0) ? ST_FIN : ST_ACC;
         ST_ACC:  if (row_q == n_q) state_nxt = ST_SYNC;
         ST_SYNC: begin
            if (sync_go)      state_nxt = ST_DIV;
            else if (timeout) state_nxt = ST_IDLE;
         end
         ST_DIV:  if (row_q == n_q + 1'b1) state_nxt = ST_FIN;
         ST_FIN:  state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= ST_IDLE;
         n_q        <= '0;
         row_q      <= '0;
         wait_q     <= '0;
         sync_rdy_q <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state <= state_nxt;
         if (start_ok) n_q <= n_req;
         row_q <= ((state_nxt == state) && ((state == ST_ACC) || (state == ST_DIV)))
                  ? row_q + 1'b1 : '0;
         if (state_nxt == ST_SYNC)
            wait_q <= (wait_q == WAIT_MAX) ? wait_q : wait_q + 1'b1;
         else
            wait_q <= '0;
         sync_rdy_q <= (state_nxt == ST_SYNC);
         done_q     <= (state == ST_FIN) || timeout;
         if (start_ok)     err_q <= 1'b0;
         else if (timeout) err_q <= 1'b1;
      end
   end

   sfp_norm_ctrl_issue_pipe u_pipe (
      .clk         (clk),
      .reset_n     (reset_n),
      .rd_en       (rd_en),
      .rd_addr     (rd_addr),
      .phase_div   (phase_div),
      .acc         (bus.acc),
      .div         (bus.div),
      .fifo_ext_rd (bus.fifo_ext_rd),
      .wr_en       (bus.wr_en),
      .wr_addr     (bus.wr_addr)
   );

   assign bus.rd_en    = rd_en;
   assign bus.rd_addr  = rd_addr;
   assign bus.sync_rdy = sync_rdy_q;
   assign bus.busy     = (state != ST_IDLE);
   assign bus.done     = done_q;
   assign bus.err      = err_q;

endmodule

// File: tb/tb_sfp_norm_ctrl.sv
// Directed bench: two sequencers (SYNC_TO=8) with selectable peer wiring.
// Cycle k = interval after the k-th posedge; outputs sampled 1ns after that edge.
module tb_sfp_norm_ctrl;
   import sfp_norm_ctrl_pkg::*;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [1:0] pmode;     // 0: A peer from peer_drv, 1: A loopback, 2: A<->B cross
   logic       peer_drv;

   always #5 clk = ~clk;

   sfp_norm_ctrl_if ia ();
   sfp_norm_ctrl_if ib ();

   assign ia.peer_rdy = (pmode == 2'd0) ? peer_drv :
                        (pmode == 2'd1) ? ia.sync_rdy : ib.sync_rdy;
   assign ib.peer_rdy = (pmode == 2'd2) ? ia.sync_rdy : 1'b0;

   sfp_norm_ctrl #(.ROWS_MAX(16), .SYNC_TO(8)) ua (.clk(clk), .reset_n(reset_n), .bus(ia));
   sfp_norm_ctrl #(.ROWS_MAX(16), .SYNC_TO(8)) ub (.clk(clk), .reset_n(reset_n), .bus(ib));

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int t0;
   int acc_n[2], div_n[2], fx_n[2], rd_n[2], wr_n[2], done_n[2], bad_n[2];
   int first_acc[2], last_acc[2], first_div[2], done_at[2];
   logic [63:0] wr_seq[2];
   logic [63:0] rd_seq[2];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clr();
      for (int i = 0; i < 2; i++) begin
         acc_n[i] = 0; div_n[i] = 0; fx_n[i] = 0; rd_n[i] = 0; wr_n[i] = 0;
         done_n[i] = 0; bad_n[i] = 0;
         first_acc[i] = -1; last_acc[i] = -1; first_div[i] = -1; done_at[i] = -1;
         wr_seq[i] = '0; rd_seq[i] = '0;
      end
   endtask

   task automatic note(input int i, input logic acc, input logic div, input logic fx,
                       input logic rd, input logic [3:0] ra, input logic wr,
                       input logic [3:0] wa, input logic dn, input logic sy,
                       input logic bsy);
      if (acc) begin
         acc_n[i]++;
         if (first_acc[i] < 0) first_acc[i] = cyc;
         last_acc[i] = cyc;
      end
      if (div) begin
         div_n[i]++;
         if (first_div[i] < 0) first_div[i] = cyc;
      end
      if (fx) fx_n[i]++;
      if (rd) begin
         rd_n[i]++;
         rd_seq[i] = {rd_seq[i][59:0], ra};
      end
      if (wr) begin
         wr_n[i]++;
         wr_seq[i] = {wr_seq[i][59:0], wa};
      end
      if (dn) begin
         done_n[i]++;
         done_at[i] = cyc;
      end
      if ((acc && div) || (div != fx) || (rd && (sy || !bsy))) bad_n[i]++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      note(0, ia.acc, ia.div, ia.fifo_ext_rd, ia.rd_en, ia.rd_addr, ia.wr_en,
           ia.wr_addr, ia.done, ia.sync_rdy, ia.busy);
      note(1, ib.acc, ib.div, ib.fifo_ext_rd, ib.rd_en, ib.rd_addr, ib.wr_en,
           ib.wr_addr, ib.done, ib.sync_rdy, ib.busy);
   endtask

   task automatic start_a(input logic [4:0] n);
      t0 = cyc;
      ia.num_rows = n;
      ia.start = 1'b1;
      tick();
      ia.start = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0;
      ia.start = 1'b0; ia.num_rows = '0;
      ib.start = 1'b0; ib.num_rows = '0;
      pmode = 2'd0; peer_drv = 1'b0;
      clr();
      repeat (3) tick();
      chk("rst_outs_a", {ia.busy, ia.done, ia.err, ia.rd_en, ia.sync_rdy, ia.acc, ia.div,
                         ia.fifo_ext_rd, ia.wr_en, ia.rd_addr, ia.wr_addr}, 64'h0);
      chk("rst_outs_b", {ib.busy, ib.done, ib.err, ib.rd_en, ib.sync_rdy, ib.wr_en}, 64'h0);
      reset_n = 1'b1;
      tick();

      // n=4, loopback peer
      pmode = 2'd1; clr();
      start_a(5'd4);
      chk("t1_busy", ia.busy, 1);
      repeat (20) tick();
      chk("t1_first_acc", first_acc[0], t0 + 2);
      chk("t1_last_acc",  last_acc[0],  t0 + 5);
      chk("t1_acc_n",     acc_n[0], 4);
      chk("t1_div_n",     div_n[0], 4);
      chk("t1_fx_n",      fx_n[0], 4);
      chk("t1_rd_seq",    rd_seq[0][31:0], 32'h0123_0123);
      chk("t1_wr_seq",    wr_seq[0][15:0], 16'h0123);
      chk("t1_wr_n",      wr_n[0], 4);
      chk("t1_done_n",    done_n[0], 1);
      chk("t1_done_at",   done_at[0], t0 + 14);
      chk("t1_err",       ia.err, 0);
      chk("t1_bad",       bad_n[0], 0);

      // cross-wired pair, B starts 5 cycles after A
      pmode = 2'd2; clr();
      start_a(5'd4);
      repeat (4) tick();
      ib.num_rows = 5'd4; ib.start = 1'b1;
      tick();
      ib.start = 1'b0;
      repeat (25) tick();
      chk("t2_div_a",  first_div[0], t0 + 13);
      chk("t2_div_b",  first_div[1], t0 + 13);
      chk("t2_done_a", done_at[0], t0 + 19);
      chk("t2_done_b", done_at[1], t0 + 19);
      chk("t2_divn_a", div_n[0], 4);
      chk("t2_divn_b", div_n[1], 4);
      chk("t2_err",    {ia.err, ib.err}, 0);
      chk("t2_bad",    bad_n[0] + bad_n[1], 0);

      // empty pass, then clamped pass
      pmode = 2'd1; clr();
      start_a(5'd0);
      repeat (6) tick();
      chk("t3_n0_done_at", done_at[0], t0 + 2);
      chk("t3_n0_done_n",  done_n[0], 1);
      chk("t3_n0_quiet",   acc_n[0] + div_n[0] + rd_n[0] + wr_n[0], 0);
      clr();
      start_a(5'd20);
      repeat (45) tick();
      chk("t3_n20_acc",     acc_n[0], 16);
      chk("t3_n20_div",     div_n[0], 16);
      chk("t3_n20_wr",      wr_n[0], 16);
      chk("t3_n20_done_at", done_at[0], t0 + 38);
      chk("t3_n20_bad",     bad_n[0], 0);

      // SYNC timeout, then recovery
      pmode = 2'd0; peer_drv = 1'b0; clr();
      start_a(5'd2);
      repeat (14) tick();
      chk("t4_to_done_at", done_at[0], t0 + 12);
      chk("t4_to_done_n",  done_n[0], 1);
      chk("t4_to_div",     div_n[0], 0);
      chk("t4_to_err",     ia.err, 1);
      chk("t4_to_busy",    ia.busy, 0);
      peer_drv = 1'b1; clr();
      start_a(5'd3);
      chk("t4_err_clr",    ia.err, 0);
      repeat (20) tick();
      chk("t4_div_n",      div_n[0], 3);
      chk("t4_done_at",    done_at[0], t0 + 12);
      chk("t4_err_end",    ia.err, 0);

      // restart ignored while busy
      pmode = 2'd1; clr();
      start_a(5'd4);
      tick();
      ia.num_rows = 5'd8; ia.start = 1'b1;
      tick();
      ia.start = 1'b0; ia.num_rows = 5'd4;
      repeat (18) tick();
      chk("t5_acc_n",   acc_n[0], 4);
      chk("t5_div_n",   div_n[0], 4);
      chk("t5_done_n",  done_n[0], 1);
      chk("t5_done_at", done_at[0], t0 + 14);

      // reset during DIV aborts immediately
      clr();
      start_a(5'd4);
      repeat (8) tick();
      chk("t5_pre_rst_div", {ia.busy, ia.rd_en}, 2'b11);
      reset_n = 1'b0;
      #1;
      chk("t5_rst_async", {ia.busy, ia.rd_en, ia.acc, ia.div, ia.fifo_ext_rd, ia.wr_en,
                           ia.sync_rdy, ia.done, ia.err, ia.rd_addr, ia.wr_addr}, 64'h0);
      repeat (2) tick();
      reset_n = 1'b1;
      clr();
      repeat (10) tick();
      chk("t5_no_resume", {ia.busy, 24'(done_n[0] + rd_n[0])}, 64'h0);
      clr();
      start_a(5'd4);
      repeat (20) tick();
      chk("t5_fresh_acc",  acc_n[0], 4);
      chk("t5_fresh_div",  div_n[0], 4);
      chk("t5_fresh_wr",   wr_seq[0][15:0], 16'h0123);
      chk("t5_fresh_done", done_at[0], t0 + 14);
      chk("t5_fresh_bad",  bad_n[0], 0);

      // peer_rdy rises exactly when the wait counter reaches SYNC_TO
      pmode = 2'd0; peer_drv = 1'b0; clr();
      start_a(5'd1);
      repeat (9) tick();
      peer_drv = 1'b1;
      tick();
      peer_drv = 1'b0;
      repeat (10) tick();
      chk("t6_first_div", first_div[0], t0 + 12);
      chk("t6_div_n",     div_n[0], 1);
      chk("t6_err",       ia.err, 0);
      chk("t6_done_at",   done_at[0], t0 + 15);
      chk("t6_done_n",    done_n[0], 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
